// File: rtl/cmos_sim_pkg.sv
// Shared definitions for the CMOS camera pattern source.
//   mode_e    : test-pattern select encodings
//   state_e   : run/stop sequencing states
//   LFSR_TAPS : feedback mask for x^16+x^14+x^13+x^11+1 (left-shifting Fibonacci form)
//   lfsr_step : one LFSR advance
package cmos_sim_pkg;

  typedef enum logic [1:0] {
    MODE_LFSR  = 2'd0,
    MODE_HRAMP = 2'd1,
    MODE_VRAMP = 2'd2,
    MODE_DIAG  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  // Bit i of the register stands for x^(i+1), so taps 15/13/12/10 give x^16/x^14/x^13/x^11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cmos_pattern_source_lfsr16.sv
// 16-bit Fibonacci LFSR used as the pseudo-random pixel source.
//   clk   : clock
//   rst_n : synchronous active-low reset (register returns to seed)
//   load  : reload register with seed
//   seed  : reload value (nonzero)
//   step  : advance one position; when asserted with load, the seed is
//           loaded and advanced in the same cycle
//   q     : current register value
module lfsr16
  import cmos_sim_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;
  logic [15:0] base;

  always_comb begin
    base = load ? seed : q_q;
    q_d  = step ? lfsr_step(base) : base;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cmos_pattern_source.sv
// CMOS camera source model: sync/href timing, pixel clock-enable and
// selectable test-pattern data, with run/stop control that only stops on a
// frame boundary and a completed-frame counter.
//   cmos_xclk    : clock
//   rst_n        : synchronous active-low reset
//   en           : run request
//   mode         : pattern select (LFSR, horizontal ramp, vertical ramp, diagonal+frame)
//   cmos_pclk_en : pixel tick strobe; other outputs change only on ticks
//   cmos_vsync   : frame sync, polarity from VSYNC_POL
//   cmos_href    : line valid
//   cmos_data    : pixel data, zero outside the active window
//   frame_cnt    : completed frame count
//   frame_done   : one-clock pulse after the last tick of each frame
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | counters held at 0, no frame output, waiting for en
// ST_RUN  | frame generation, counters advancing
// ST_STOP | en dropped; finishing the current frame, then IDLE
module cmos_pattern_source
  import cmos_sim_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          IMG_HDISP = 640,
  parameter int          IMG_VDISP = 480,
  parameter int          H_SYNC    = 5,
  parameter int          H_BACK    = 5,
  parameter int          H_FRONT   = 5,
  parameter int          V_SYNC    = 1,
  parameter int          V_BACK    = 0,
  parameter int          V_FRONT   = 1,
  parameter bit          VSYNC_POL = 1'b1,
  parameter int          PCLK_DIV  = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              cmos_xclk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic              cmos_pclk_en,
  output logic              cmos_vsync,
  output logic              cmos_href,
  output logic [DATA_W-1:0] cmos_data,
  output logic [15:0]       frame_cnt,
  output logic              frame_done
);

  localparam int H_TOTAL = H_SYNC + H_BACK + IMG_HDISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + IMG_VDISP + V_FRONT;

  localparam logic [15:0] H_ACT_S  = 16'(H_SYNC + H_BACK);
  localparam logic [15:0] H_ACT_E  = 16'(H_SYNC + H_BACK + IMG_HDISP);
  localparam logic [15:0] V_ACT_S  = 16'(V_SYNC + V_BACK);
  localparam logic [15:0] V_ACT_E  = 16'(V_SYNC + V_BACK + IMG_VDISP);
  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] V_SYNC_C = 16'(V_SYNC);
  localparam logic [1:0]  PC_LAST  = 2'(PCLK_DIV - 1);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [1:0]         pc_q, pc_d;
  logic [15:0]        hcnt_q, hcnt_d;
  logic [15:0]        vcnt_q, vcnt_d;
  logic               href_q, href_d;
  logic               vsync_q, vsync_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               frame_done_q, frame_done_d;

  logic               tick;
  logic               in_frame;
  logic               active;
  logic               frame_start;
  logic               last_tick;
  logic [15:0]        x;
  logic [15:0]        y;
  logic [15:0]        pat;
  logic [15:0]        lfsr_q;
  logic [15:0]        lfsr_cur;
  mode_e              mode_cur;
  logic               lfsr_ld;
  logic               lfsr_adv;
  logic               unused_pat_hi;

  assign tick = (pc_q == PC_LAST);

  // Frame start is also honoured in STOP: a RUN->STOP transition on the last
  // tick rolls into one more complete frame, which must still latch mode and
  // reload the LFSR like any other frame.
  always_comb begin
    in_frame    = (state_q != ST_IDLE);
    active      = in_frame &&
                  (vcnt_q >= V_ACT_S) && (vcnt_q < V_ACT_E) &&
                  (hcnt_q >= H_ACT_S) && (hcnt_q < H_ACT_E);
    frame_start = in_frame && (hcnt_q == 16'd0) && (vcnt_q == 16'd0);
    last_tick   = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
    x           = hcnt_q - H_ACT_S;
    y           = vcnt_q - V_ACT_S;
    // With zero porches the first pixel coincides with frame start, so the
    // freshly latched mode and seed are forwarded for that tick.
    mode_cur    = frame_start ? mode_e'(mode) : mode_q;
    lfsr_cur    = frame_start ? LFSR_SEED : lfsr_q;
    case (mode_cur)
      MODE_LFSR:  pat = lfsr_cur;
      MODE_HRAMP: pat = x;
      MODE_VRAMP: pat = y;
      default:    pat = x + y + {8'h00, frame_cnt_q[7:0]};
    endcase
    lfsr_ld  = tick && frame_start;
    lfsr_adv = tick && active;
  end

  // Pattern bits above DATA_W are dropped when DATA_W < 16.
  assign unused_pat_hi = ^pat;

  lfsr16 u_lfsr (
    .clk   (cmos_xclk),
    .rst_n (rst_n),
    .load  (lfsr_ld),
    .seed  (LFSR_SEED),
    .step  (lfsr_adv),
    .q     (lfsr_q)
  );

  always_comb begin
    pc_d         = tick ? 2'd0 : pc_q + 2'd1;
    state_d      = state_q;
    mode_d       = mode_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    href_d       = href_q;
    vsync_d      = vsync_q;
    data_d       = data_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;

    if (tick) begin
      href_d  = active;
      vsync_d = in_frame && (vcnt_q >= V_SYNC_C);
      data_d  = active ? pat[DATA_W-1:0] : '0;
      if (frame_start) begin
        mode_d = mode_e'(mode);
      end

      if (state_q == ST_IDLE) begin
        hcnt_d = 16'd0;
        vcnt_d = 16'd0;
        if (en) begin
          state_d = ST_RUN;
        end
      end else begin
        if (hcnt_q == H_LAST) begin
          hcnt_d = 16'd0;
          vcnt_d = (vcnt_q == V_LAST) ? 16'd0 : vcnt_q + 16'd1;
        end else begin
          hcnt_d = hcnt_q + 16'd1;
        end
        if (last_tick) begin
          frame_cnt_d  = frame_cnt_q + 16'd1;
          frame_done_d = 1'b1;
        end
        if (state_q == ST_RUN) begin
          if (!en) begin
            state_d = ST_STOP;
          end
        end else begin
          // A renewed request wins over stopping on the final tick.
          if (en) begin
            state_d = ST_RUN;
          end else if (last_tick) begin
            state_d = ST_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge cmos_xclk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_LFSR;
      pc_q         <= 2'd0;
      hcnt_q       <= 16'd0;
      vcnt_q       <= 16'd0;
      href_q       <= 1'b0;
      vsync_q      <= 1'b0;
      data_q       <= '0;
      frame_cnt_q  <= 16'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      pc_q         <= pc_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      href_q       <= href_d;
      vsync_q      <= vsync_d;
      data_q       <= data_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign cmos_pclk_en = tick;
  assign cmos_vsync   = VSYNC_POL ? vsync_q : ~vsync_q;
  assign cmos_href    = href_q;
  assign cmos_data    = data_q;
  assign frame_cnt    = frame_cnt_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_cmos_pattern_source.sv
// Directed bench for cmos_pattern_source with an 8x4 image and default
// porches (H_TOTAL=23, V_TOTAL=6, 138 ticks per frame).
//   u0 : PCLK_DIV=1, VSYNC_POL=1 (main scenarios)
//   u1 : PCLK_DIV=3
//   u2 : VSYNC_POL=0
module tb_cmos_pattern_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en;
  logic [1:0] mode;
  logic       pclk0, vs0, href0, fdone0;
  logic [7:0] data0;
  logic [15:0] fcnt0;

  logic       rst1_n, en1;
  logic [1:0] mode1;
  logic       pclk1, vs1, href1, fdone1;
  logic [7:0] data1;
  logic [15:0] fcnt1;

  logic       rst2_n, en2;
  logic [1:0] mode2;
  logic       pclk2, vs2, href2, fdone2;
  logic [7:0] data2;
  logic [15:0] fcnt2;

  cmos_pattern_source #(.IMG_HDISP(8), .IMG_VDISP(4)) u0 (
    .cmos_xclk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .cmos_pclk_en(pclk0), .cmos_vsync(vs0), .cmos_href(href0),
    .cmos_data(data0), .frame_cnt(fcnt0), .frame_done(fdone0));

  cmos_pattern_source #(.IMG_HDISP(8), .IMG_VDISP(4), .PCLK_DIV(3)) u1 (
    .cmos_xclk(clk), .rst_n(rst1_n), .en(en1), .mode(mode1),
    .cmos_pclk_en(pclk1), .cmos_vsync(vs1), .cmos_href(href1),
    .cmos_data(data1), .frame_cnt(fcnt1), .frame_done(fdone1));

  cmos_pattern_source #(.IMG_HDISP(8), .IMG_VDISP(4), .VSYNC_POL(1'b0)) u2 (
    .cmos_xclk(clk), .rst_n(rst2_n), .en(en2), .mode(mode2),
    .cmos_pclk_en(pclk2), .cmos_vsync(vs2), .cmos_href(href2),
    .cmos_data(data2), .frame_cnt(fcnt2), .frame_done(fdone2));

  int err_cnt = 0;
  int chk_cnt = 0;
  int k = 0;
  int first_href_k = -1;
  int frame_px = 0;
  int run_len = 0;
  int idle_viol = 0;
  logic [7:0] pix_q[$];
  int done_k[$];
  int px_q[$];
  int runs[$];
  logic [7:0] model[32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic clear_mon();
    pix_q.delete();
    done_k.delete();
    px_q.delete();
    runs.delete();
  endtask

  task automatic run_u0(input int frames, input int budget, output int got);
    got = 0;
    for (int i = 0; i < budget && got < frames; i++) begin
      step();
      if (href0) begin
        pix_q.push_back(data0);
        frame_px++;
        run_len++;
        if (first_href_k < 0) first_href_k = k;
      end else begin
        if (data0 != 8'd0) idle_viol++;
        if (run_len > 0) begin
          runs.push_back(run_len);
          run_len = 0;
        end
      end
      if (fdone0) begin
        got++;
        done_k.push_back(k);
        px_q.push_back(frame_px);
        frame_px = 0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int got;
    logic [15:0] s;

    rst_n = 1'b0; en = 1'b0; mode = 2'd1;
    rst1_n = 1'b0; en1 = 1'b0; mode1 = 2'd1;
    rst2_n = 1'b0; en2 = 1'b0; mode2 = 2'd0;

    s = 16'hACE1;
    for (int i = 0; i < 32; i++) begin
      model[i] = s[7:0];
      s = lfsr_next(s);
    end

    // Reset state
    step(); step();
    check("rst_href", href0, 0);
    check("rst_data", data0, 0);
    check("rst_vsync", vs0, 0);
    check("rst_fcnt", fcnt0, 0);
    check("rst_fdone", fdone0, 0);
    check("rst_pclk_div1", pclk0, 1);

    // Scenario 1: horizontal ramp, two frames
    rst_n = 1'b1; en = 1'b1; mode = 2'd1;
    k = 0; first_href_k = -1; clear_mon();
    run_u0(2, 400, got);
    check("s1_frames", got, 2);
    check("s1_first_href", first_href_k, 35);
    check("s1_done0_k", (done_k.size() > 0) ? done_k[0] : -1, 139);
    check("s1_done_gap", (done_k.size() > 1) ? done_k[1] - done_k[0] : -1, 138);
    check("s1_px_f0", (px_q.size() > 0) ? px_q[0] : -1, 32);
    check("s1_px_f1", (px_q.size() > 1) ? px_q[1] : -1, 32);
    check("s1_lines", runs.size(), 8);
    for (int i = 0; i < runs.size(); i++) check("s1_line_len", runs[i], 8);
    for (int i = 0; i < pix_q.size(); i++) check("s1_hramp", pix_q[i], i % 8);
    check("s1_fcnt", fcnt0, 2);

    // Scenario 2: LFSR, two frames with identical content
    mode = 2'd0;
    clear_mon();
    run_u0(2, 400, got);
    check("s2_frames", got, 2);
    check("s2_npix", pix_q.size(), 64);
    check("s2_first", (pix_q.size() > 0) ? pix_q[0] : 8'h00, 8'hE1);
    for (int i = 0; i < pix_q.size(); i++) check("s2_lfsr", pix_q[i], model[i % 32]);
    check("s2_idle_data", idle_viol, 0);
    check("s2_fcnt", fcnt0, 4);

    // Scenario 6: mode 1 -> 2 mid-frame
    mode = 2'd1;
    clear_mon();
    run_u0(1, 60, got);
    check("s6_midframe", got, 0);
    mode = 2'd2;
    run_u0(1, 200, got);
    check("s6_frame_a", got, 1);
    run_u0(1, 200, got);
    check("s6_frame_b", got, 1);
    check("s6_npix", pix_q.size(), 64);
    for (int i = 0; i < pix_q.size(); i++)
      check("s6_ramp", pix_q[i], (i < 32) ? (i % 8) : ((i - 32) / 8));
    check("s6_fcnt", fcnt0, 6);

    // Scenario 4: en dropped in line 2, mode 3
    mode = 2'd3;
    clear_mon();
    run_u0(1, 50, got);
    check("s4_pre_drop", got, 0);
    en = 1'b0;
    run_u0(1, 200, got);
    check("s4_completed", got, 1);
    check("s4_px", (px_q.size() > 0) ? px_q[0] : -1, 32);
    for (int i = 0; i < pix_q.size(); i++)
      check("s4_diag", pix_q[i], (i % 8) + (i / 8) + 6);
    check("s4_fcnt", fcnt0, 7);
    run_u0(1, 300, got);
    check("s4_idle_nodone", got, 0);
    check("s4_idle_vsync", vs0, 0);
    check("s4_idle_href", href0, 0);
    en = 1'b1;
    k = 0; first_href_k = -1; clear_mon();
    run_u0(1, 400, got);
    check("s4_restart_href", first_href_k, 35);
    check("s4_restart_done", (done_k.size() > 0) ? done_k[0] : -1, 139);
    check("s4_restart_p0", (pix_q.size() > 0) ? pix_q[0] : 8'hFF, 7);
    check("s4_restart_p31", (pix_q.size() > 31) ? pix_q[31] : 8'hFF, 17);

    // Scenario 5: reset pulse mid-line
    got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      step();
      if (href0) got = 1;
    end
    check("s5_href_seen", got, 1);
    step(); step(); step();
    check("s5_midline", href0, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("s5_href", href0, 0);
    check("s5_data", data0, 0);
    check("s5_vsync", vs0, 0);
    check("s5_fcnt", fcnt0, 0);
    check("s5_fdone", fdone0, 0);
    run_u0(1, 100, got);
    check("s5_no_done", got, 0);
    check("s5_fcnt_hold", fcnt0, 0);

    // Scenario 3: PCLK_DIV=3
    begin
      int gap_viol, chg_viol, last_pk, href_clks, nd;
      int dk[2];
      logic pp, ph, pv;
      logic [7:0] pd;
      gap_viol = 0; chg_viol = 0; last_pk = -1; href_clks = 0; nd = 0;
      dk[0] = -1; dk[1] = -1;
      step();
      check("s3_rst_pclk", pclk1, 0);
      check("s3_rst_href", href1, 0);
      check("s3_rst_vsync", vs1, 0);
      check("s3_rst_fcnt", fcnt1, 0);
      rst1_n = 1'b1; en1 = 1'b1; mode1 = 2'd1;
      pp = pclk1; ph = href1; pv = vs1; pd = data1;
      for (int i = 0; i < 1200 && nd < 2; i++) begin
        step();
        if (!pp && (href1 != ph || vs1 != pv || data1 != pd)) chg_viol++;
        if (pclk1) begin
          if (last_pk >= 0 && (k - last_pk) != 3) gap_viol++;
          last_pk = k;
        end
        if (href1) href_clks++;
        if (fdone1) begin
          dk[nd] = k;
          nd++;
        end
        pp = pclk1; ph = href1; pv = vs1; pd = data1;
      end
      check("s3_frames", nd, 2);
      check("s3_pclk_gap", gap_viol, 0);
      check("s3_change_off_tick", chg_viol, 0);
      check("s3_frame_clks", dk[1] - dk[0], 414);
      check("s3_href_clks", href_clks, 192);
      check("s3_fcnt", fcnt1, 2);
    end

    // VSYNC_POL=0: idle level high, low once inside the frame
    step();
    check("pol0_rst_vsync", vs2, 1);
    rst2_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("pol0_idle_vsync", vs2, 1);
    en2 = 1'b1;
    for (int i = 0; i < 40; i++) step();
    check("pol0_run_vsync", vs2, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/cmos_pattern_source.md
# cmos_pattern_source

Parametrised CMOS camera source model for simulation and on-chip self-test. It generates sync and `href` timing, a pixel clock-enable, and selectable test-pattern data. It sits in front of the video pipeline (gray/median filters, frame-difference logic) in place of a real sensor. It extends the fixed single-mode simulator with:
- configurable porches and data width
- a pixel-rate divider
- run/stop control that stops only at a frame boundary
- four deterministic data patterns
- a frame counter.

## Interface
Parameters:
- DATA_W, 8, pixel width; legal range 1..16
- IMG_HDISP, 640, active pixels per line
- IMG_VDISP, 480, active lines per frame
- H_SYNC / H_BACK / H_FRONT, 5 / 5 / 5, horizontal sync, back porch and front porch, in pixel ticks
- V_SYNC / V_BACK / V_FRONT, 1 / 0 / 1, vertical sync, back porch and front porch, in lines
- VSYNC_POL, 1, 1: `cmos_vsync` is high while data is valid; 0: the output is inverted
- PCLK_DIV, 1, one pixel tick every PCLK_DIV clocks; legal range 1..4
- LFSR_SEED, 16'hACE1, LFSR reload value; must be nonzero

Ports:
- cmos_xclk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- en  in  1  run request
- mode  in  2  pattern select: 0 = LFSR, 1 = horizontal ramp, 2 = vertical ramp, 3 = diagonal + frame
- cmos_pclk_en  out  1  pixel tick strobe; all other outputs change only on this tick
- cmos_vsync  out  1  frame sync, polarity set by VSYNC_POL
- cmos_href  out  1  line valid
- cmos_data  out  DATA_W  pixel data
- frame_cnt  out  16  count of completed frames
- frame_done  out  1  one-clock pulse at the end of each frame

## Operation
Constants:
- H_TOTAL = H_SYNC + H_BACK + IMG_HDISP + H_FRONT
- V_TOTAL = V_SYNC + V_BACK + IMG_VDISP + V_FRONT

Pixel tick:
- Prescaler `pc` counts 0..PCLK_DIV-1 continuously while out of reset.
- `cmos_pclk_en` = (`pc` == PCLK_DIV-1), combinational from `pc`.

Counters and state machine (all updates occur only on ticks):
- `hcnt` counts 0..H_TOTAL-1 and wraps. `vcnt` increments when `hcnt` wraps, and itself wraps at V_TOTAL-1.
- IDLE: counters held at 0; no frame outputs are generated. Go to RUN when `en`=1 is sampled on a tick.
- RUN: counters advance. If `en`=0 is sampled, go to STOP.
- STOP: counters keep advancing. If `en`=1 is sampled, return to RUN. At the last tick of the frame (`hcnt`=H_TOTAL-1 and `vcnt`=V_TOTAL-1), go to IDLE with the counters at 0.
- A frame is never truncated.

Frame start:
- Frame start is the tick where `hcnt`=0 and `vcnt`=0 in RUN.
- At frame start, `mode` is latched and the LFSR is reloaded with LFSR_SEED.
- A change to `mode` mid-frame takes effect at the next frame.

Output generation:
- `active` = (V_SYNC+V_BACK ≤ `vcnt` < V_SYNC+V_BACK+IMG_VDISP) and (H_SYNC+H_BACK ≤ `hcnt` < H_SYNC+H_BACK+IMG_HDISP).
- `x` = `hcnt` − (H_SYNC+H_BACK); `y` = `vcnt` − (V_SYNC+V_BACK).
- On each tick:
  - `cmos_href` ← `active`.
  - `vsync_int` ← (state≠IDLE and `vcnt` ≥ V_SYNC).
  - `cmos_data` ← `pattern` when `active`, else 0.
- `cmos_vsync` = `vsync_int` when VSYNC_POL=1, else ~`vsync_int`.

Patterns (all truncated to the low DATA_W bits):
- 0: `lfsr[DATA_W-1:0]`. The 16-bit Fibonacci LFSR uses polynomial x^16+x^14+x^13+x^11+1 and advances after each active pixel.
- 1: `x`.
- 2: `y`.
- 3: `x` + `y` + `frame_cnt[7:0]`, modulo 2^DATA_W.

Frame counter:
- At the last tick of every frame, `frame_cnt` increments (wrapping 16'hFFFF → 0) and `frame_done` pulses for exactly one clock.

Reset:
- Synchronous, on the clock edge with `rst_n`=0, with priority over the tick.
- Reset values: state IDLE, `pc`/`hcnt`/`vcnt`=0, `cmos_href`=0, `cmos_data`=0, `vsync_int`=0 (so `cmos_vsync` = ~VSYNC_POL), `frame_cnt`=0, `frame_done`=0.
- Reset mid-frame discards the frame; no `frame_done` pulse is issued.

## Timing
- Output latency: each output is registered and reflects the counter value of the previous tick, i.e. one tick of latency.
- `href`/data alignment: `cmos_href` and `cmos_data` are aligned; `cmos_data` is valid on every tick where `cmos_href`=1.
- Start latency: from `en` sampled high in IDLE, the first `href` occurs (V_SYNC+V_BACK)·H_TOTAL + H_SYNC+H_BACK+1 ticks later.
- Line and frame length: exactly IMG_HDISP consecutive `href` ticks per line and IMG_VDISP lines per frame.
- PCLK_DIV=1: `cmos_pclk_en` is constantly 1, i.e. one pixel per clock.

## Structure
- Package `cmos_sim_pkg`:
  - mode encodings (LFSR, HRAMP, VRAMP, DIAG)
  - state encoding (IDLE, RUN, STOP)
  - LFSR tap mask 16'hB400
- Sub-module `lfsr16`, with ports: clk, rst_n, load, seed, step, q[15:0].
- Timing counters, state machine and output registers stay in the top level.

## Test plan
Scenarios 1–5 use IMG 8×4 and default porches, giving H_TOTAL=23, V_TOTAL=6 and 138 ticks per frame.
1. Mode 1, `en`=1 held for 2 frames → 4 lines of 8 `href` ticks per frame, each line with data 0..7; `frame_done` fires 138 clocks apart; `frame_cnt`=2 at the end.
2. Mode 0 over 2 frames → both frames carry an identical data sequence whose first pixel is 8'hE1; no data value is emitted while `href`=0.
3. PCLK_DIV=3 → `cmos_pclk_en` is high once every 3 clocks; `href`/`vsync`/data change only on ticks; one frame spans 414 clocks.
4. `en` dropped at line 2 of a frame (mode 3) → the frame completes in full with `frame_done`=1, the block then returns to IDLE and `cmos_vsync` returns to its reset level; raising `en` again restarts at `vcnt`=0.
5. `rst_n` low for 1 clock mid-line → on the next clock all outputs equal their reset values and `frame_cnt` is unchanged from 0, with no `frame_done` pulse; with VSYNC_POL=0, `cmos_vsync`=1 while idle.
6. `mode` changed mid-frame from 1 to 2 → the current frame stays a horizontal ramp; the next frame shows each line constant at `y` = 0,1,2,3.
